// File: rtl/dcnn_psum_collector.sv
// Per-lane partial-sum accumulator with a single drain bank, serialised
// lane-by-lane onto a valid/ready stream toward the output buffer.
//
// state | meaning
// IDLE  | inputs ignored, waiting for cfg_start
// ACC   | accumulating channels into per-lane accumulators
// WAIT  | row complete, drain bank still occupied; incoming psums are dropped
module dcnn_psum_collector #(
  parameter int DW               = 32,
  parameter int MAX_PARA_OUT     = 64,
  parameter int MAX_PARA_OUT_BIT = 7,
  parameter int CH_BITS          = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic                                cfg_stop,
  input  logic [MAX_PARA_OUT_BIT-1:0]         para_out_num,
  input  logic [CH_BITS-1:0]                  ch_num,
  input  logic [MAX_PARA_OUT-1:0][DW-1:0]     psum_in,
  input  logic [MAX_PARA_OUT-1:0]             psum_in_vld,
  output logic [DW-1:0]                       out_data,
  output logic [MAX_PARA_OUT_BIT-1:0]         out_lane,
  output logic                                out_last,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic                                busy,
  output logic [15:0]                         row_cnt,
  output logic                                ovf_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT} state_t;
  state_t state, state_nx;

  logic [MAX_PARA_OUT_BIT-1:0] n_act, n_clamp, didx;
  logic [CH_BITS-1:0]          ch_lat, ch_clamp;
  logic [DW-1:0]               acc     [MAX_PARA_OUT];
  logic [CH_BITS-1:0]          cnt     [MAX_PARA_OUT];
  logic [DW-1:0]               dbank   [MAX_PARA_OUT];
  logic [DW-1:0]               sat_sum [MAX_PARA_OUT];
  logic [MAX_PARA_OUT-1:0]     lane_act, lane_done, lane_zero, acc_en, drop;
  logic                        dfull, stop_pend, all_done, all_zero;
  logic                        in_row, beat, last_beat, drain_free, handoff;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return s[DW-1:0];
  endfunction

  assign n_clamp  = (para_out_num == '0) ? MAX_PARA_OUT_BIT'(1) :
                    (para_out_num > MAX_PARA_OUT_BIT'(MAX_PARA_OUT)) ? MAX_PARA_OUT_BIT'(MAX_PARA_OUT) :
                    para_out_num;
  assign ch_clamp = (ch_num == '0) ? CH_BITS'(1) : ch_num;

  assign in_row     = (state == S_ACC) || (state == S_WAIT);
  assign all_done   = &(~lane_act | lane_done);
  assign all_zero   = &(~lane_act | lane_zero);
  assign beat       = dfull && out_rdy;
  assign last_beat  = beat && out_last;
  assign drain_free = !dfull || last_beat;
  assign handoff    = in_row && all_done && drain_free;

  always_comb begin
    lane_act  = '0;
    lane_done = '0;
    lane_zero = '0;
    acc_en    = '0;
    drop      = '0;
    for (int i = 0; i < MAX_PARA_OUT; i++) begin
      lane_act[i]  = MAX_PARA_OUT_BIT'(i) < n_act;
      lane_done[i] = cnt[i] == ch_lat;
      lane_zero[i] = cnt[i] == '0;
      sat_sum[i]   = sat_add(acc[i], psum_in[i]);
      acc_en[i]    = (state == S_ACC) && !handoff && lane_act[i] && psum_in_vld[i] && !lane_done[i];
      drop[i]      = in_row && !handoff && lane_act[i] && psum_in_vld[i] && lane_done[i];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_ACC: begin
        if (handoff)                     state_nx = stop_pend ? S_IDLE : S_ACC;
        else if (all_done)               state_nx = S_WAIT;
        else if (stop_pend && all_zero)  state_nx = S_IDLE;
      end
      S_WAIT: if (handoff)               state_nx = stop_pend ? S_IDLE : S_ACC;
      default:                           state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)            state <= S_IDLE;
    else if (cfg_start) state <= S_ACC;
    else                state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_start) begin
      n_act     <= rst ? '0 : n_clamp;
      ch_lat    <= rst ? '0 : ch_clamp;
      dfull     <= 1'b0;
      didx      <= '0;
      stop_pend <= 1'b0;
      row_cnt   <= '0;
      ovf_err   <= 1'b0;
      for (int i = 0; i < MAX_PARA_OUT; i++) begin
        acc[i]   <= '0;
        cnt[i]   <= '0;
        dbank[i] <= '0;
      end
    end else begin
      if (state != S_IDLE && state_nx == S_IDLE) stop_pend <= 1'b0;
      else if (cfg_stop)                         stop_pend <= 1'b1;
      if (|drop) ovf_err <= 1'b1;
      // Next-row psums arriving on the handoff edge seed the fresh accumulators
      for (int i = 0; i < MAX_PARA_OUT; i++) begin
        if (handoff) begin
          dbank[i] <= acc[i];
          acc[i]   <= (lane_act[i] && psum_in_vld[i]) ? psum_in[i] : '0;
          cnt[i]   <= (lane_act[i] && psum_in_vld[i]) ? CH_BITS'(1) : '0;
        end else if (acc_en[i]) begin
          acc[i]   <= lane_zero[i] ? psum_in[i] : sat_sum[i];
          cnt[i]   <= cnt[i] + CH_BITS'(1);
        end
      end
      if (handoff) begin
        row_cnt <= row_cnt + 16'd1;
        dfull   <= 1'b1;
        didx    <= '0;
      end else if (last_beat) begin
        dfull   <= 1'b0;
        didx    <= '0;
      end else if (beat) begin
        didx    <= didx + MAX_PARA_OUT_BIT'(1);
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < MAX_PARA_OUT; i++)
      if (MAX_PARA_OUT_BIT'(i) == didx) out_data = dbank[i];
  end

  assign out_lane = didx;
  assign out_vld  = dfull;
  assign out_last = dfull && (didx == n_act - MAX_PARA_OUT_BIT'(1));
  assign busy     = (state != S_IDLE) || dfull;

endmodule

// File: tb/tb_dcnn_psum_collector.sv
// Scoreboard bench for dcnn_psum_collector: expected beats are queued as rows
// are driven and checked by a monitor as the DUT drains them.
module tb_dcnn_psum_collector;
  localparam int DW = 8;
  localparam int MP = 8;
  localparam int MB = 4;
  localparam int CB = 4;

  logic              clk = 0;
  logic              rst, cfg_start, cfg_stop, out_rdy;
  logic [MB-1:0]     para_out_num;
  logic [CB-1:0]     ch_num;
  logic [MP-1:0][DW-1:0] psum_in;
  logic [MP-1:0]     psum_in_vld;
  logic [DW-1:0]     out_data;
  logic [MB-1:0]     out_lane;
  logic              out_last, out_vld, busy, ovf_err;
  logic [15:0]       row_cnt;

  typedef struct packed {
    logic [MB-1:0] lane;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  beat_t sb[$];

  int checks = 0;
  int errors = 0;

  dcnn_psum_collector #(.DW(DW), .MAX_PARA_OUT(MP), .MAX_PARA_OUT_BIT(MB), .CH_BITS(CB)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .para_out_num(para_out_num), .ch_num(ch_num), .psum_in(psum_in), .psum_in_vld(psum_in_vld),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last), .out_vld(out_vld),
    .out_rdy(out_rdy), .busy(busy), .row_cnt(row_cnt), .ovf_err(ovf_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      beat_t got, exp;
      got = '{lane: out_lane, data: out_data, last: out_last};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got lane=%0d data=%0d last=%0b, none expected",
                 out_lane, $signed(out_data), out_last);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL beat: got lane=%0d data=%0d last=%0b, expected lane=%0d data=%0d last=%0b",
                   got.lane, $signed(got.data), got.last, exp.lane, $signed(exp.data), exp.last);
        end
      end
    end
  end

  function automatic int sat(input int s);
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lane, input int data, input bit last);
    sb.push_back('{lane: MB'(lane), data: DW'(data), last: last});
  endtask

  task automatic configure(input int n, input int ch);
    para_out_num = MB'(n);
    ch_num       = CB'(ch);
    cfg_start    = 1;
    cyc();
    cfg_start    = 0;
  endtask

  task automatic drive2(input logic [MP-1:0] v, input int d0, input int d1);
    psum_in     = '0;
    psum_in[0]  = DW'(d0);
    psum_in[1]  = DW'(d1);
    psum_in_vld = v;
    cyc();
    psum_in_vld = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d beats still outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1; cfg_start = 0; cfg_stop = 0; out_rdy = 1;
    para_out_num = '0; ch_num = '0; psum_in = '0; psum_in_vld = '0;
    repeat (3) cyc();
    rst = 0;
    cyc();
    checks++;
    if ({out_vld, busy, ovf_err, out_last} !== 4'b0 || row_cnt !== 16'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: vld=%0b busy=%0b ovf=%0b last=%0b row_cnt=%0d data=%0d, expected all 0",
               out_vld, busy, ovf_err, out_last, row_cnt, out_data);
    end
  endtask

  task automatic test_basic();
    out_rdy = 1;
    configure(2, 3);
    push(0, 6, 0); push(1, 60, 1);
    drive2(2'b11, 1, 10);
    drive2(2'b11, 2, 20);
    drive2(2'b11, 3, 30);
    check_val("basic_vld_after_E0", out_vld, 0);
    cyc();
    check_val("basic_vld_after_E1", out_vld, 1);
    check_val("basic_first_lane", out_lane, 0);
    wait_drain("basic");
    check_val("basic_row_cnt", row_cnt, 1);
    check_val("basic_ovf", ovf_err, 0);
  endtask

  task automatic test_saturation();
    out_rdy = 1;
    configure(1, 2);
    push(0, sat(100 + 100), 1);
    push(0, sat(-100 - 100), 1);
    drive2(2'b01, 100, 0);
    drive2(2'b01, 100, 0);
    drive2(2'b01, -100, 0);
    drive2(2'b01, -100, 0);
    wait_drain("sat");
    check_val("sat_row_cnt", row_cnt, 2);
    check_val("sat_ovf", ovf_err, 0);
  endtask

  task automatic test_backpressure();
    out_rdy = 0;
    configure(2, 1);
    push(0, 5, 0); push(1, 6, 1); push(0, 7, 0); push(1, 8, 1);
    drive2(2'b11, 5, 6);
    repeat (2) cyc();
    drive2(2'b11, 7, 8);
    repeat (3) cyc();
    check_val("bp_hold_data", out_data, 5);
    check_val("bp_hold_lane", out_lane, 0);
    check_val("bp_ovf_before", ovf_err, 0);
    drive2(2'b01, 99, 0);
    check_val("bp_ovf_wait", ovf_err, 1);
    check_val("bp_hold_data_late", out_data, 5);
    out_rdy = 1;
    wait_drain("bp");
    check_val("bp_row_cnt", row_cnt, 2);
  endtask

  task automatic test_back_to_back();
    out_rdy = 1;
    configure(2, 2);
    push(0, 4, 0); push(1, 6, 1); push(0, 15, 0); push(1, 110, 1);
    drive2(2'b11, 1, 2);
    drive2(2'b11, 3, 4);
    drive2(2'b10, 0, 50);
    drive2(2'b11, 7, 60);
    drive2(2'b01, 8, 0);
    wait_drain("b2b");
    check_val("b2b_ovf", ovf_err, 0);
    check_val("b2b_row_cnt", row_cnt, 2);
  endtask

  task automatic test_reset_mid_drain();
    out_rdy = 0;
    configure(2, 1);
    drive2(2'b11, 1, 2);
    drive2(2'b11, 3, 4);
    drive2(2'b11, 5, 6);
    cyc();
    check_val("rstmid_vld_before", out_vld, 1);
    check_val("rstmid_ovf_before", ovf_err, 1);
    rst = 1;
    cyc();
    rst = 0;
    check_val("rstmid_vld", out_vld, 0);
    check_val("rstmid_busy", busy, 0);
    check_val("rstmid_row_cnt", row_cnt, 0);
    check_val("rstmid_ovf", ovf_err, 0);
    out_rdy = 1;
  endtask

  task automatic test_zero_cfg();
    out_rdy = 1;
    configure(0, 0);
    push(0, 5, 1); push(0, -3, 1); push(0, 9, 1);
    drive2(2'b11, 5, 44);
    drive2(2'b01, -3, 0);
    drive2(2'b11, 9, 45);
    wait_drain("zero");
    check_val("zero_row_cnt", row_cnt, 3);
    check_val("zero_ovf", ovf_err, 0);
    cfg_stop = 1;
    cyc();
    cfg_stop = 0;
    repeat (2) cyc();
    check_val("stop_busy", busy, 0);
  endtask

  task automatic test_clamp();
    out_rdy = 1;
    configure(12, 1);
    psum_in = '0;
    for (int i = 0; i < MP; i++) begin
      psum_in[i] = DW'(i * 3 + 1);
      push(i, i * 3 + 1, i == MP - 1);
    end
    psum_in_vld = '1;
    cyc();
    psum_in_vld = '0;
    wait_drain("clamp");
    check_val("clamp_row_cnt", row_cnt, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_zero_cfg();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
